// File: rtl/twiddle_quarter_wave_gen.sv
`timescale 1ns/1ps
// twiddle_quarter_wave_gen
//   Full-circle radix-2 FFT/IFFT twiddle generator driven from a quarter-wave
//   cosine ROM. Each accepted angle index k takes two ROM reads (cos, then sin).
//   Four-quadrant symmetry and optional conjugation are applied, and the signed
//   complex result goes into a first-word fall-through output FIFO that
//   honours backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (at most one request per 2 cycles)
//   in_k                angle index, theta = 2*pi*k/2**TW_N
//   in_ifft             1: W = e^{+j*theta}, 0: W = e^{-j*theta}
//   in_tag              user tag, returned unchanged with the twiddle
//   rom_en/rom_addr     quarter-wave ROM read port
//   rom_data            ROM word, available one cycle after rom_en
//   out_valid/out_ready twiddle handshake
//   out_re/out_im       signed real / imaginary part (TW_DW+1 bits)
//   out_tag             tag of the twiddle at the FIFO head
module twiddle_quarter_wave_gen #(
   parameter int TW_N       = 10,
   parameter int TW_DW      = 16,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TW_N-1:0]         in_k,
   input  logic                    in_ifft,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    rom_en,
   output logic [TW_N-3:0]         rom_addr,
   input  logic [TW_DW-1:0]        rom_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [TW_DW:0]   out_re,
   output logic signed [TW_DW:0]   out_im,
   output logic [TAG_W-1:0]        out_tag
);

   localparam int AW = TW_N - 2;
   localparam int OW = TW_DW + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {S_COS = 1'b0, S_SIN = 1'b1} state_t;

   // Unsigned ROM magnitude widened by one bit so later negation cannot overflow.
   function automatic logic signed [OW-1:0] f_zext(input logic [TW_DW-1:0] v);
      return signed'({1'b0, v});
   endfunction

   function automatic logic signed [OW-1:0] f_neg(input logic signed [OW-1:0] v);
      return -v;
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_credit_ok;
   logic [CW:0]           w_credit_sum;
   logic [AW-1:0]         w_sin_addr;

   logic [1:0]            r_q_p0;
   logic [AW-1:0]         r_r_p0;
   logic                  r_ifft_p0;
   logic [TAG_W-1:0]      r_tag_p0;
   logic                  r_inflight;

   logic [TW_DW-1:0]      r_c_p1;
   logic                  r_vld_p1;

   logic signed [OW-1:0]  w_c;
   logic signed [OW-1:0]  w_s;
   logic signed [OW-1:0]  w_cos_t;
   logic signed [OW-1:0]  w_sin_t;
   logic signed [OW-1:0]  w_im;

   logic signed [OW-1:0]  r_fifo_re  [FIFO_DEPTH];
   logic signed [OW-1:0]  r_fifo_im  [FIFO_DEPTH];
   logic [TAG_W-1:0]      r_fifo_tag [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   // A request is only accepted if its result is guaranteed a FIFO slot,
   // counting the one that may still be travelling through the pipeline.
   assign w_credit_sum = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_credit_ok  = (w_credit_sum < (CW+1)'(FIFO_DEPTH));

   // NQ - r truncated to the address width is simply the two's complement of r.
   assign w_sin_addr   = '0 - r_r_p0;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      in_ready    = 1'b0;
      rom_en      = 1'b0;
      rom_addr    = '0;
      if (rst_n) begin
         case (r_state)
            S_COS: begin
               in_ready = w_credit_ok;
               if (in_valid && w_credit_ok) begin
                  w_accept    = 1'b1;
                  rom_en      = 1'b1;
                  rom_addr    = in_k[AW-1:0];
                  w_state_nxt = S_SIN;
               end
            end
            S_SIN: begin
               // r==0 needs no sine read; the sine is forced to zero downstream.
               rom_en      = (r_r_p0 != '0);
               rom_addr    = w_sin_addr;
               w_state_nxt = S_COS;
            end
            default: w_state_nxt = S_COS;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_COS;
         r_inflight <= 1'b0;
         r_vld_p1   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_vld_p1 <= (r_state == S_SIN);
         if (w_accept)
            r_inflight <= 1'b1;
         else if (w_push)
            r_inflight <= 1'b0;
      end
   end

   // ---- stage p0: request latched on accept ----
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_q_p0    <= in_k[TW_N-1:AW];
         r_r_p0    <= in_k[AW-1:0];
         r_ifft_p0 <= in_ifft;
         r_tag_p0  <= in_tag;
      end
   end

   // ---- stage p1: cosine word captured in the S_SIN cycle ----
   always_ff @(posedge clk) begin
      if (r_state == S_SIN)
         r_c_p1 <= rom_data;
   end

   // ---- stage p2: sine word arrives, quadrant map, conjugation, FIFO push ----
   always_comb begin
      w_c     = f_zext(r_c_p1);
      w_s     = f_zext((r_r_p0 == '0) ? '0 : rom_data);
      w_cos_t = w_c;
      w_sin_t = w_s;
      case (r_q_p0)
         2'd0: begin w_cos_t = w_c;         w_sin_t = w_s;         end
         2'd1: begin w_cos_t = f_neg(w_s);  w_sin_t = w_c;         end
         2'd2: begin w_cos_t = f_neg(w_c);  w_sin_t = f_neg(w_s);  end
         default: begin w_cos_t = w_s;      w_sin_t = f_neg(w_c);  end
      endcase
      w_im = r_ifft_p0 ? w_sin_t : f_neg(w_sin_t);
   end

   assign w_push    = r_vld_p1;
   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_re[r_wr_ptr]  <= w_cos_t;
         r_fifo_im[r_wr_ptr]  <= w_im;
         r_fifo_tag[r_wr_ptr] <= r_tag_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head entry is presented only while valid so the data outputs read zero
   // when empty and throughout reset.
   assign out_re  = out_valid ? r_fifo_re[r_rd_ptr]  : '0;
   assign out_im  = out_valid ? r_fifo_im[r_rd_ptr]  : '0;
   assign out_tag = out_valid ? r_fifo_tag[r_rd_ptr] : '0;

endmodule
